// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM states, halt-instruction encodings and defaults for the fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_ECALL       = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;

    function automatic logic is_halt_inst(input logic [31:0] inst);
        return (inst == INST_ECALL) || (inst == INST_EBREAK);
    endfunction

endpackage

// File: rtl/fetch_unit_imem_loader.sv
// fetch_unit_imem_loader: streams boot words into instmemory's write port and pulses done on the final word.
module fetch_unit_imem_loader
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PROG_WORDS = 32
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        active_i,
    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_waddr_o,
    output logic [31:0] imem_wdata_o,
    output logic        done_o
);

    logic [31:0] cnt_q, cnt_d;

    // Reset gates the write port combinationally so nothing is written while it is held.
    assign load_ready_o = active_i && !reset_i;
    assign imem_we_o    = load_ready_o && load_valid_i;
    assign imem_waddr_o = cnt_q;
    assign imem_wdata_o = load_data_i;
    assign done_o       = imem_we_o && (load_last_i || cnt_q == 32'(PROG_WORDS - 1));

    always_comb begin
        cnt_d = imem_we_o ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, boots instmemory through its write port, then fetches until ECALL/EBREAK.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned PROG_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic        load_done, in_run, halt_now;

    fetch_unit_imem_loader #(
        .PROG_WORDS(PROG_WORDS)
    ) u_imem_loader (
        .clock_i     (clock),
        .reset_i     (reset),
        .active_i    (state_q == ST_LOAD),
        .load_valid_i(load_valid),
        .load_data_i (load_data),
        .load_last_i (load_last),
        .load_ready_o(load_ready),
        .imem_we_o   (imem_we),
        .imem_waddr_o(imem_waddr),
        .imem_wdata_o(imem_wdata),
        .done_o      (load_done)
    );

    assign in_run   = (state_q == ST_RUN) && !reset;
    assign halt_now = !stall && !redirect && is_halt_inst(imem_rdata);

    // Redirect outranks stall; a halting instruction keeps pc pointing at itself.
    always_comb begin
        pc_d     = (state_q == ST_LOAD && load_done) ? RESET_PC :
                   (state_q != ST_RUN)               ? pc_q :
                   redirect                          ? {redirect_pc[31:2], 2'b00} :
                   (stall || halt_now)               ? pc_q : pc_q + 32'd4;
        state_d  = (state_q == ST_LOAD && load_done) ? ST_RUN :
                   (state_q == ST_RUN && halt_now)   ? ST_HALT : state_q;
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = {2'b00, pc_q[31:2]};
    assign inst       = imem_rdata;
    assign inst_valid = in_run && !stall;
    assign halted     = halted_q && !reset;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit with a behavioural instmemory model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset, load_valid, load_last, stall, redirect;
    logic [31:0] load_data, redirect_pc, imem_rdata;
    logic        load_ready, imem_we, inst_valid, halted;
    logic [31:0] imem_addr, imem_waddr, imem_wdata, pc, inst;
    logic [31:0] mem [0:31];

    logic        reset2, load_valid2, load_last2;
    logic [31:0] load_data2, rdata2;
    logic        load_ready2, imem_we2, inst_valid2, halted2;
    logic [31:0] imem_addr2, imem_waddr2, imem_wdata2, pc2, inst2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .imem_we(imem_we), .imem_rdata(imem_rdata), .pc(pc),
        .inst(inst), .inst_valid(inst_valid), .halted(halted)
    );

    fetch_unit #(.PROG_WORDS(4)) dut2 (
        .clock(clock), .reset(reset2), .load_valid(load_valid2), .load_data(load_data2),
        .load_last(load_last2), .load_ready(load_ready2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_addr(imem_addr2), .imem_waddr(imem_waddr2),
        .imem_wdata(imem_wdata2), .imem_we(imem_we2), .imem_rdata(rdata2), .pc(pc2),
        .inst(inst2), .inst_valid(inst_valid2), .halted(halted2)
    );

    assign rdata2     = 32'h0000_0013;
    assign imem_rdata = mem[imem_addr[4:0]];

    always @(posedge clock) if (imem_we) mem[imem_waddr[4:0]] <= imem_wdata;

    task automatic test_reset;
        reset = 1; load_valid = 1; load_data = 32'hDEAD_BEEF; load_last = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        @(negedge clock);
        #1;
        checks += 4;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
        if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got %b want 0", imem_we); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        @(negedge clock);
        reset = 0; load_valid = 0;
        #1;
        checks += 2;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL post_rst_load_ready got %b want 1", load_ready); end
        if (pc !== 32'h0) begin errors++; $display("FAIL post_rst_pc got %h want 0", pc); end
        @(negedge clock);
    endtask

    task automatic test_load;
        logic [31:0] w [3];
        w[0] = 32'h00A2_00B3; w[1] = 32'h0000_0013; w[2] = 32'h0000_0073;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = w[i]; load_last = (i == 2);
            #1;
            checks += 3;
            if (imem_we !== 1'b1) begin errors++; $display("FAIL load_we[%0d] got %b want 1", i, imem_we); end
            if (imem_waddr !== 32'(i)) begin errors++; $display("FAIL load_waddr[%0d] got %0d want %0d", i, imem_waddr, i); end
            if (imem_wdata !== w[i]) begin errors++; $display("FAIL load_wdata[%0d] got %h want %h", i, imem_wdata, w[i]); end
            @(negedge clock);
        end
        load_valid = 0; load_last = 0;
        #1;
        checks += 5;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL run_load_ready got %b want 0", load_ready); end
        if (pc !== 32'h0) begin errors++; $display("FAIL run_pc0 got %h want 0", pc); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL run_addr0 got %h want 0", imem_addr); end
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL run_valid0 got %b want 1", inst_valid); end
        if (inst !== 32'h00A2_00B3) begin errors++; $display("FAIL run_inst0 got %h want 00a200b3", inst); end
        @(negedge clock);
    endtask

    task automatic test_run;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks += 3;
            if (pc !== 32'(4 * i)) begin errors++; $display("FAIL run_pc[%0d] got %h want %h", i, pc, 4 * i); end
            if (imem_addr !== 32'(i)) begin errors++; $display("FAIL run_addr[%0d] got %h want %h", i, imem_addr, i); end
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got %b want 1", i, inst_valid); end
            @(negedge clock);
        end
        #1;
        checks += 3;
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
        if (pc !== 32'h8) begin errors++; $display("FAIL halt_pc got %h want 8", pc); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", inst_valid); end
        redirect = 1; redirect_pc = 32'h40; load_valid = 1;
        @(negedge clock);
        #1;
        checks += 3;
        if (pc !== 32'h8) begin errors++; $display("FAIL halt_frozen_pc got %h want 8", pc); end
        if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", halted); end
        if (imem_we !== 1'b0) begin errors++; $display("FAIL halt_we got %b want 0", imem_we); end
        redirect = 0; load_valid = 0;
        @(negedge clock);
    endtask

    task automatic test_stall;
        logic [31:0] w [4];
        w[0] = 32'h13; w[1] = 32'h13; w[2] = 32'h13; w[3] = 32'h0010_0073;
        reset = 1;
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = w[i]; load_last = (i == 3);
            @(negedge clock);
        end
        load_valid = 0; load_last = 0;
        @(negedge clock);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks += 2;
            if (pc !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d] got %h want 4", i, pc); end
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b want 0", i, inst_valid); end
            @(negedge clock);
        end
        stall = 0;
        #1;
        checks += 2;
        if (pc !== 32'h4) begin errors++; $display("FAIL unstall_pc got %h want 4", pc); end
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid got %b want 1", inst_valid); end
        @(negedge clock);
        #1;
        checks++;
        if (pc !== 32'h8) begin errors++; $display("FAIL resume_pc got %h want 8", pc); end
        @(negedge clock);
    endtask

    task automatic test_redirect;
        // pc is 0xC here only if the redirect is ignored; drive redirect at pc=8's successor.
        redirect = 1; redirect_pc = 32'h0000_0013; stall = 1;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_stall_valid got %b want 0", inst_valid); end
        @(negedge clock);
        redirect = 0; stall = 0;
        #1;
        checks += 2;
        if (pc !== 32'h10) begin errors++; $display("FAIL redir_pc got %h want 10", pc); end
        if (imem_addr !== 32'h4) begin errors++; $display("FAIL redir_addr got %h want 4", imem_addr); end
        redirect = 1; redirect_pc = 32'h0000_000E;
        @(negedge clock);
        redirect = 0;
        #1;
        checks += 3;
        if (pc !== 32'hC) begin errors++; $display("FAIL ebreak_pc got %h want c", pc); end
        if (inst !== 32'h0010_0073) begin errors++; $display("FAIL ebreak_inst got %h want 00100073", inst); end
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL ebreak_valid got %b want 1", inst_valid); end
        @(negedge clock);
        #1;
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("FAIL ebreak_halted got %b want 1", halted); end
        if (pc !== 32'hC) begin errors++; $display("FAIL ebreak_hold_pc got %h want c", pc); end
        @(negedge clock);
    endtask

    task automatic test_reset_reload;
        reset = 1;
        #1;
        checks += 2;
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halt_flag got %b want 0", halted); end
        if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_halt_ready got %b want 0", load_ready); end
        @(negedge clock);
        reset = 0;
        #1;
        checks += 2;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reload_ready got %b want 1", load_ready); end
        if (pc !== 32'h0) begin errors++; $display("FAIL reload_pc got %h want 0", pc); end
        for (int i = 0; i < 2; i++) begin
            load_valid = 1; load_data = 32'hA0 + 32'(i); load_last = 0;
            #1;
            checks++;
            if (imem_waddr !== 32'(i)) begin errors++; $display("FAIL part_waddr[%0d] got %0d want %0d", i, imem_waddr, i); end
            @(negedge clock);
        end
        load_valid = 0;
        #1;
        checks++;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", imem_we); end
        @(negedge clock);
        load_valid = 1;
        #1;
        checks++;
        if (imem_waddr !== 32'd2) begin errors++; $display("FAIL held_waddr got %0d want 2", imem_waddr); end
        load_valid = 0; reset = 1;
        @(negedge clock);
        reset = 0; load_valid = 1; load_data = 32'hB0;
        #1;
        checks += 2;
        if (imem_we !== 1'b1) begin errors++; $display("FAIL restart_we got %b want 1", imem_we); end
        if (imem_waddr !== 32'd0) begin errors++; $display("FAIL restart_waddr got %0d want 0", imem_waddr); end
        @(negedge clock);
        load_valid = 0;
    endtask

    task automatic test_prog_words;
        reset2 = 1;
        @(negedge clock);
        reset2 = 0;
        for (int i = 0; i < 6; i++) begin
            load_valid2 = 1; load_data2 = 32'h100 + 32'(i); load_last2 = 0;
            #1;
            if (i < 4) begin
                checks += 2;
                if (imem_we2 !== 1'b1) begin errors++; $display("FAIL cap_we[%0d] got %b want 1", i, imem_we2); end
                if (imem_waddr2 !== 32'(i)) begin errors++; $display("FAIL cap_waddr[%0d] got %0d want %0d", i, imem_waddr2, i); end
            end else begin
                checks += 3;
                if (imem_we2 !== 1'b0) begin errors++; $display("FAIL cap_we[%0d] got %b want 0", i, imem_we2); end
                if (load_ready2 !== 1'b0) begin errors++; $display("FAIL cap_ready[%0d] got %b want 0", i, load_ready2); end
                if (inst_valid2 !== 1'b1) begin errors++; $display("FAIL cap_valid[%0d] got %b want 1", i, inst_valid2); end
            end
            @(negedge clock);
        end
        load_valid2 = 0;
    endtask

    initial begin
        reset2 = 1; load_valid2 = 0; load_data2 = 0; load_last2 = 0;
        @(negedge clock);
        test_reset();
        test_load();
        test_run();
        test_stall();
        test_redirect();
        test_reset_reload();
        test_prog_words();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
